// File: rtl/truco_pkg.sv
// Shared types and constants for the truco bet/hand controller.
package truco_pkg;

   typedef enum logic [1:0] {
      OCIOSO       = 2'd0,
      AGUARDA_RESP = 2'd1,
      ENVIA        = 2'd2,
      FIM          = 2'd3
   } aposta_estado_t;

   typedef enum logic {
      EQ_A = 1'b0,
      EQ_B = 1'b1
   } equipe_t;

   localparam logic [2:0] IDX_MAX = 3'd4;
   localparam logic [3:0] VALOR_MAO [5] = '{4'd1, 4'd3, 4'd6, 4'd9, 4'd12};

   function automatic logic [3:0] valor_de(input logic [2:0] idx);
      logic [3:0] v;
      v = 4'd12;
      for (int i = 0; i < 5; i++) begin
         if (idx == 3'(i)) v = VALOR_MAO[i];
      end
      return v;
   endfunction

endpackage

// File: rtl/truco_pulsador.sv
// Emits a train of single-cycle point pulses to one team, each followed by PULSE_GAP low cycles.
module truco_pulsador
   import truco_pkg::*;
#(
   parameter int PULSE_GAP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       carga_i,
   input  logic       aborta_i,
   input  logic [3:0] qtd_i,
   input  equipe_t    alvo_i,
   output logic       ponto_a_o,
   output logic       ponto_b_o,
   output logic       ocupado_o,
   output logic       fim_o,
   output logic       termina_o
);

   localparam int GW = $clog2(PULSE_GAP + 1);

   logic          pa_q, pa_d, pb_q, pb_d;
   logic          ocupado_q, ocupado_d;
   logic          fim_q, fim_d;
   logic [3:0]    restante_q, restante_d;
   logic [GW-1:0] gap_q, gap_d;
   equipe_t       alvo_q, alvo_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pa_q       <= 1'b0;
         pb_q       <= 1'b0;
         ocupado_q  <= 1'b0;
         fim_q      <= 1'b0;
         restante_q <= 4'd0;
         gap_q      <= '0;
         alvo_q     <= EQ_A;
      end else begin
         pa_q       <= pa_d;
         pb_q       <= pb_d;
         ocupado_q  <= ocupado_d;
         fim_q      <= fim_d;
         restante_q <= restante_d;
         gap_q      <= gap_d;
         alvo_q     <= alvo_d;
      end
   end

   // Last low cycle of the last gap: the train ends on the coming edge.
   assign termina_o = ocupado_q && !(pa_q || pb_q) && (gap_q == GW'(1)) && (restante_q == 4'd0);

   always_comb begin
      pa_d       = 1'b0;
      pb_d       = 1'b0;
      fim_d      = 1'b0;
      ocupado_d  = ocupado_q;
      restante_d = restante_q;
      gap_d      = gap_q;
      alvo_d     = alvo_q;
      if (aborta_i) begin
         ocupado_d  = 1'b0;
         restante_d = 4'd0;
         gap_d      = '0;
      end else if (ocupado_q) begin
         if (pa_q || pb_q) begin
            gap_d = GW'(PULSE_GAP);
         end else if (gap_q == GW'(1)) begin
            if (restante_q == 4'd0) begin
               ocupado_d = 1'b0;
               fim_d     = 1'b1;
            end else begin
               restante_d = restante_q - 4'd1;
               pa_d       = (alvo_q == EQ_A);
               pb_d       = (alvo_q == EQ_B);
            end
         end else begin
            gap_d = gap_q - GW'(1);
         end
      end else if (carga_i) begin
         ocupado_d  = 1'b1;
         restante_d = qtd_i - 4'd1;
         alvo_d     = alvo_i;
         pa_d       = (alvo_i == EQ_A);
         pb_d       = (alvo_i == EQ_B);
      end
   end

   assign ponto_a_o = pa_q;
   assign ponto_b_o = pb_q;
   assign ocupado_o = ocupado_q;
   assign fim_o     = fim_q;

endmodule

// File: rtl/truco_aposta_ctrl.sv
// Truco raise arbitration and hand-value tracking; pays the hand out as point pulses to the scoreboard.
//  state        | meaning
//  OCIOSO       | hand open, raises and wins accepted
//  AGUARDA_RESP | raise pending, waiting for the responding team
//  ENVIA        | point pulse train running
//  FIM          | game over, only rst leaves
module truco_aposta_ctrl
   import truco_pkg::*;
#(
   parameter int PULSE_GAP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pedido_a,
   input  logic       pedido_b,
   input  logic       aceita,
   input  logic       corre,
   input  logic       vence_a,
   input  logic       vence_b,
   input  logic       jogo_encerrado,
   output logic       ponto_a,
   output logic       ponto_b,
   output logic [3:0] valor_mao,
   output logic       pedido_pendente,
   output logic       vez_resposta,
   output logic       ocupado,
   output logic       mao_fim
);

   aposta_estado_t estado_q, estado_d;
   logic [2:0]     idx_q, idx_d, pend_idx_q, pend_idx_d;
   equipe_t        vez_q, vez_d, ult_q, ult_d, prio_q, prio_d;
   logic           ult_ok_q, ult_ok_d;
   logic           pendente_q, pendente_d;
   logic [3:0]     valor_q, valor_d;

   logic    eleg_a, eleg_b, req_a, req_b, contra, termina;
   logic    carga, aborta;
   equipe_t ganho, raiser, alvo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q   <= OCIOSO;
         idx_q      <= 3'd0;
         pend_idx_q <= 3'd0;
         vez_q      <= EQ_A;
         ult_q      <= EQ_A;
         ult_ok_q   <= 1'b0;
         prio_q     <= EQ_A;
         pendente_q <= 1'b0;
         valor_q    <= 4'd1;
      end else begin
         estado_q   <= estado_d;
         idx_q      <= idx_d;
         pend_idx_q <= pend_idx_d;
         vez_q      <= vez_d;
         ult_q      <= ult_d;
         ult_ok_q   <= ult_ok_d;
         prio_q     <= prio_d;
         pendente_q <= pendente_d;
         valor_q    <= valor_d;
      end
   end

   assign raiser = equipe_t'(~vez_q);
   assign contra = (vez_q == EQ_B) ? pedido_b : pedido_a;
   assign eleg_a = !(ult_ok_q && (ult_q == EQ_A)) && (idx_q < IDX_MAX);
   assign eleg_b = !(ult_ok_q && (ult_q == EQ_B)) && (idx_q < IDX_MAX);
   assign req_a  = pedido_a && eleg_a;
   assign req_b  = pedido_b && eleg_b;
   assign ganho  = (req_a && req_b) ? prio_q : (req_b ? EQ_B : EQ_A);

   always_comb begin
      estado_d   = estado_q;
      idx_d      = idx_q;
      pend_idx_d = pend_idx_q;
      vez_d      = vez_q;
      ult_d      = ult_q;
      ult_ok_d   = ult_ok_q;
      prio_d     = prio_q;
      if (jogo_encerrado) begin
         estado_d = FIM;
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (vence_a ^ vence_b) begin
                  estado_d = ENVIA;
               end else if (req_a || req_b) begin
                  pend_idx_d = idx_q + 3'd1;
                  vez_d      = equipe_t'(~ganho);
                  estado_d   = AGUARDA_RESP;
               end
            end
            AGUARDA_RESP: begin
               if (corre) begin
                  estado_d = ENVIA;
               end else if (aceita || contra) begin
                  idx_d    = pend_idx_q;
                  ult_d    = raiser;
                  ult_ok_d = 1'b1;
                  // A counter-raise on top of the last rung degenerates to a plain accept.
                  if (!aceita && (pend_idx_q < IDX_MAX)) begin
                     pend_idx_d = pend_idx_q + 3'd1;
                     vez_d      = raiser;
                  end else begin
                     estado_d = OCIOSO;
                  end
               end
            end
            ENVIA: begin
               if (termina) begin
                  idx_d    = 3'd0;
                  ult_ok_d = 1'b0;
                  prio_d   = equipe_t'(~prio_q);
                  estado_d = OCIOSO;
               end
            end
            default: estado_d = FIM;
         endcase
      end
      if (estado_d == FIM) vez_d = EQ_A;
      pendente_d = (estado_d == AGUARDA_RESP);
      valor_d    = valor_de(idx_d);
   end

   always_comb begin
      carga  = 1'b0;
      aborta = 1'b0;
      alvo   = EQ_A;
      if (estado_d == FIM) begin
         aborta = 1'b1;
      end else if ((estado_q != ENVIA) && (estado_d == ENVIA)) begin
         carga = 1'b1;
         alvo  = (estado_q == AGUARDA_RESP) ? raiser : (vence_b ? EQ_B : EQ_A);
      end
   end

   truco_pulsador #(.PULSE_GAP(PULSE_GAP)) u_pulsador (
      .clk       (clk),
      .rst       (rst),
      .carga_i   (carga),
      .aborta_i  (aborta),
      .qtd_i     (valor_q),
      .alvo_i    (alvo),
      .ponto_a_o (ponto_a),
      .ponto_b_o (ponto_b),
      .ocupado_o (ocupado),
      .fim_o     (mao_fim),
      .termina_o (termina)
   );

   assign valor_mao       = valor_q;
   assign pedido_pendente = pendente_q;
   assign vez_resposta    = vez_q;

endmodule

// File: tb/tb_truco_aposta_ctrl.sv
// Directed and randomized bench for truco_aposta_ctrl against a hand-level reference model.
module tb_truco_aposta_ctrl;
   localparam int G = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pedido_a = 0, pedido_b = 0, aceita = 0, corre = 0, vence_a = 0, vence_b = 0;
   logic jogo_encerrado = 0;
   logic ponto_a, ponto_b, pedido_pendente, vez_resposta, ocupado, mao_fim;
   logic [3:0] valor_mao;

   int checks = 0, failures = 0;
   int m_idx, m_pidx, m_last;
   bit m_pend, m_resp, m_prio;
   int exp_a, exp_b, cnt_a, cnt_b;

   truco_aposta_ctrl #(.PULSE_GAP(G)) dut (
      .clk(clk), .rst(rst), .pedido_a(pedido_a), .pedido_b(pedido_b), .aceita(aceita),
      .corre(corre), .vence_a(vence_a), .vence_b(vence_b), .jogo_encerrado(jogo_encerrado),
      .ponto_a(ponto_a), .ponto_b(ponto_b), .valor_mao(valor_mao),
      .pedido_pendente(pedido_pendente), .vez_resposta(vez_resposta),
      .ocupado(ocupado), .mao_fim(mao_fim)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ladder(input int i);
      return (i == 0) ? 1 : 3 * i;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      {pedido_a, pedido_b, aceita, corre, vence_a, vence_b} = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      m_idx = 0; m_pidx = 0; m_last = -1; m_pend = 0; m_resp = 0; m_prio = 0;
      exp_a = 0; exp_b = 0; cnt_a = 0; cnt_b = 0;
   endtask

   task automatic model(input bit pa, pb, ac, co, va, vb, output bit st, output bit w, output int v);
      bit ra, rb, g, raiser;
      st = 0; w = 0; v = 0;
      if (!m_pend) begin
         if (va != vb) begin
            st = 1; w = vb; v = ladder(m_idx);
         end else begin
            ra = pa && (m_last != 0) && (m_idx < 4);
            rb = pb && (m_last != 1) && (m_idx < 4);
            if (ra || rb) begin
               g = (ra && rb) ? m_prio : rb;
               m_pend = 1; m_pidx = m_idx + 1; m_resp = !g;
            end
         end
      end else begin
         raiser = !m_resp;
         if (co) begin
            st = 1; w = raiser; v = ladder(m_idx); m_pend = 0;
         end else if (ac || (m_resp ? pb : pa)) begin
            m_idx = m_pidx; m_last = raiser; m_pend = 0;
            if (!ac && m_idx < 4) begin
               m_pend = 1; m_pidx = m_idx + 1; m_resp = raiser;
            end
         end
      end
      if (st) begin
         if (w) exp_b += v; else exp_a += v;
      end
   endtask

   task automatic run_train(input bit w, input int v);
      int len;
      bit p;
      len = v * (G + 1);
      for (int t = 0; t <= len; t++) begin
         p = (t < len) && (t % (G + 1) == 0);
         chk("train", {ponto_a, ponto_b, ocupado, mao_fim}, {p && !w, p && w, t < len, t == len});
         if (t == 0) chk("valor_trem", valor_mao, ladder(m_idx));
         if (ponto_a) cnt_a++;
         if (ponto_b) cnt_b++;
         if (t < len) step();
      end
      m_idx = 0; m_last = -1; m_prio = !m_prio;
      chk("valor_pos", valor_mao, 1);
      chk("placar_a", cnt_a, exp_a);
      chk("placar_b", cnt_b, exp_b);
   endtask

   task automatic drive(input bit pa, pb, ac, co, va, vb);
      bit st, w;
      int v;
      {pedido_a, pedido_b, aceita, corre, vence_a, vence_b} = {pa, pb, ac, co, va, vb};
      step();
      {pedido_a, pedido_b, aceita, corre, vence_a, vence_b} = '0;
      model(pa, pb, ac, co, va, vb, st, w, v);
      if (st) begin
         run_train(w, v);
      end else begin
         chk("valor", valor_mao, ladder(m_idx));
         chk("pendente", pedido_pendente, m_pend);
         if (m_pend) chk("vez", vez_resposta, m_resp);
         chk("ocupado_idle", ocupado, 0);
      end
   endtask

   initial begin
      int r, n, wr;
      bit p;

      do_reset();
      chk("rst_ponto_a", ponto_a, 0);
      chk("rst_ponto_b", ponto_b, 0);
      chk("rst_valor", valor_mao, 1);
      chk("rst_pend", pedido_pendente, 0);
      chk("rst_vez", vez_resposta, 0);
      chk("rst_ocupado", ocupado, 0);
      chk("rst_mao_fim", mao_fim, 0);

      drive(0, 0, 0, 0, 1, 0);
      chk("placar_a_1", cnt_a, 1);

      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      chk("valor_6", valor_mao, 6);
      drive(0, 0, 0, 0, 0, 1);

      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0);

      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      chk("contra_valor", valor_mao, 3);
      chk("contra_pend", pedido_pendente, 1);
      chk("contra_vez", vez_resposta, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0);

      // asynchronous reset must kill a pulse that is on the wire
      vence_a = 1; step(); vence_a = 0;
      chk("async_pre", ponto_a, 1);
      #1 rst = 1'b1;
      #1;
      chk("async_ponto", ponto_a, 0);
      chk("async_ocupado", ocupado, 0);

      do_reset();
      drive(1, 1, 0, 0, 0, 0);
      chk("prio_1", vez_resposta, 1);
      drive(0, 0, 0, 1, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      chk("prio_2", vez_resposta, 0);
      drive(0, 0, 0, 1, 0, 0);

      for (int h = 0; h < 25; h++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 5);
            case (r)
               0: drive(1, 0, 0, 0, 0, 0);
               1: drive(0, 1, 0, 0, 0, 0);
               2: drive(1, 1, 0, 0, 0, 0);
               3: drive(0, 0, 1, 0, 0, 0);
               4: drive(m_resp == 0, m_resp == 1, 0, 0, 0, 0);
               default: drive(0, 0, 0, 0, 1, 1);
            endcase
         end
         wr = $urandom_range(0, 1);
         if (m_pend && $urandom_range(0, 1) == 1) begin
            drive(0, 0, 0, 1, 0, 0);
         end else begin
            if (m_pend) drive(0, 0, 1, 0, 0, 0);
            drive(0, 0, 0, 0, wr == 0, wr == 1);
         end
      end

      do_reset();
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      chk("topo_valor", valor_mao, 12);
      chk("topo_pend", pedido_pendente, 0);
      drive(1, 0, 0, 0, 0, 0);
      chk("topo_ignora", pedido_pendente, 0);

      vence_b = 1; step(); vence_b = 0;
      for (int t = 0; t <= 10; t++) begin
         p = (t % (G + 1) == 0);
         chk("trem_fim", {ponto_a, ponto_b, ocupado, mao_fim}, {1'b0, p, 1'b1, 1'b0});
         if (ponto_b) cnt_b++;
         if (t < 10) step();
      end
      jogo_encerrado = 1;
      step();
      for (int t = 0; t < 20; t++) begin
         chk("fim_saidas", {ponto_a, ponto_b, ocupado, mao_fim, pedido_pendente, vez_resposta}, 0);
         chk("fim_valor", valor_mao, 12);
         if (ponto_b) cnt_b++;
         step();
      end
      chk("fim_pontos", cnt_b, 3);
      pedido_a = 1; vence_a = 1; step(); pedido_a = 0; vence_a = 0;
      chk("fim_travado", {pedido_pendente, ocupado}, 0);
      step();
      chk("fim_travado2", {ponto_a, ocupado}, 0);

      jogo_encerrado = 0;
      do_reset();
      chk("rec_valor", valor_mao, 1);
      chk("rec_pend", pedido_pendente, 0);
      drive(0, 0, 0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
